// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown with load/start/stop control.
// state   | meaning
// IDLE    | preset loaded or after reset, waiting for start_resume
// RUN     | counting down on each enable
// PAUSE   | counting halted by stop, digits held
// EXPIRED | reached 00:00, digits held until load or reset
module countdown_timer #(
  parameter bit TICK_EN_DEFAULT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_mt,
  input  logic [3:0] load_mo,
  input  logic [3:0] load_st,
  input  logic [3:0] load_so,
  input  logic       start_resume,
  input  logic       stop,
  output logic [3:0] mt,
  output logic [3:0] mo,
  output logic [3:0] st,
  output logic [3:0] so,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic       done_q, done_d;
  logic       dec_en;
  logic       is_zero;
  logic [3:0] dmt, dmo, dst, dso;

  assign dec_en  = TICK_EN_DEFAULT ? tick : 1'b1;
  assign is_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);

  // State, digit and done registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mt_q    <= 4'd0;
      mo_q    <= 4'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  // One-step BCD decrement with borrow chain; only used when digits are nonzero
  always_comb begin
    dmt = mt_q;
    dmo = mo_q;
    dst = st_q;
    dso = so_q;
    if (so_q != 4'd0) begin
      dso = so_q - 4'd1;
    end else begin
      dso = 4'd9;
      if (st_q != 4'd0) begin
        dst = st_q - 4'd1;
      end else begin
        dst = 4'd5;
        if (mo_q != 4'd0) begin
          dmo = mo_q - 4'd1;
        end else begin
          dmo = 4'd9;
          dmt = mt_q - 4'd1;
        end
      end
    end
  end

  // Next-state and next-digit logic in priority order load > stop > start > decrement
  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = IDLE;
      mt_d    = (load_mt > 4'd9) ? 4'd9 : load_mt;
      mo_d    = (load_mo > 4'd9) ? 4'd9 : load_mo;
      st_d    = (load_st > 4'd5) ? 4'd5 : load_st;
      so_d    = (load_so > 4'd9) ? 4'd9 : load_so;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (!stop && start_resume && !is_zero) state_d = RUN;
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (dec_en && !is_zero) begin
            mt_d = dmt;
            mo_d = dmo;
            st_d = dst;
            so_d = dso;
            if ((dmt == 4'd0) && (dmo == 4'd0) && (dst == 4'd0) && (dso == 4'd0)) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs decoded purely from registers
  always_comb begin
    mt      = mt_q;
    mo      = mo_q;
    st      = st_q;
    so      = so_q;
    running = (state_q == RUN);
    expired = (state_q == EXPIRED);
    done    = done_q;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (tick-enabled mode).
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, tick, load, start_resume, stop;
  logic [3:0] load_mt, load_mo, load_st, load_so;
  logic [3:0] mt, mo, st, so;
  logic       running, done, expired;
  int         tests = 0;
  int         fails = 0;

  countdown_timer #(.TICK_EN_DEFAULT(1'b1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_mt(load_mt), .load_mo(load_mo), .load_st(load_st), .load_so(load_so),
    .start_resume(start_resume), .stop(stop),
    .mt(mt), .mo(mo), .st(st), .so(so),
    .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    load = 1'b1; load_mt = a; load_mo = b; load_st = c; load_so = d;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start_resume = 1'b1;
    step();
    start_resume = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; load = 1'b0; start_resume = 1'b0; stop = 1'b0;
    load_mt = 4'd0; load_mo = 4'd0; load_st = 4'd0; load_so = 4'd0;
    step(); step();
    chk("reset_digits", {mt, mo, st, so}, 16'h0000);
    chk("reset_flags", {13'd0, running, done, expired}, 16'd0);
    reset = 1'b0;

    // 01:00 -> one tick -> 00:59
    do_load(4'd0, 4'd1, 4'd0, 4'd0);
    chk("load_0100", {mt, mo, st, so}, 16'h0100);
    chk("load_idle_running", {15'd0, running}, 16'd0);
    do_start();
    chk("start_running", {15'd0, running}, 16'd1);
    chk("start_no_dec", {mt, mo, st, so}, 16'h0100);
    do_tick();
    chk("tick_0059", {mt, mo, st, so}, 16'h0059);
    chk("tick_running", {15'd0, running}, 16'd1);

    // 00:02 -> expiry
    do_load(4'd0, 4'd0, 4'd0, 4'd2);
    chk("load_from_run_running", {15'd0, running}, 16'd0);
    do_start();
    do_tick();
    chk("tick_0001", {mt, mo, st, so}, 16'h0001);
    chk("no_done_early", {15'd0, done}, 16'd0);
    do_tick();
    chk("expire_digits", {mt, mo, st, so}, 16'h0000);
    chk("expire_flags", {13'd0, running, done, expired}, 16'b001_1);
    step();
    chk("done_one_cycle", {13'd0, running, done, expired}, 16'b0001);
    do_tick();
    chk("expired_hold", {mt, mo, st, so}, 16'h0000);
    chk("expired_level", {15'd0, expired}, 16'd1);
    do_start();
    chk("start_ignored_expired", {13'd0, running, done, expired}, 16'b0001);

    // mt borrow and st borrow
    do_load(4'd1, 4'd0, 4'd0, 4'd0);
    chk("load_clears_expired", {15'd0, expired}, 16'd0);
    do_start();
    do_tick();
    chk("borrow_0959", {mt, mo, st, so}, 16'h0959);
    do_load(4'd0, 4'd0, 4'd1, 4'd0);
    do_start();
    do_tick();
    chk("borrow_0009", {mt, mo, st, so}, 16'h0009);

    // clamping
    do_load(4'hF, 4'hA, 4'h7, 4'hC);
    chk("clamp_9959", {mt, mo, st, so}, 16'h9959);

    // stop beats tick, then resume
    do_load(4'd0, 4'd0, 4'd0, 4'd5);
    do_start();
    stop = 1'b1; tick = 1'b1;
    step();
    stop = 1'b0; tick = 1'b0;
    chk("stop_tick_digits", {mt, mo, st, so}, 16'h0005);
    chk("stop_tick_running", {15'd0, running}, 16'd0);
    do_tick();
    chk("tick_ignored_pause", {mt, mo, st, so}, 16'h0005);
    do_start();
    chk("resume_running", {15'd0, running}, 16'd1);
    do_tick();
    chk("resume_0004", {mt, mo, st, so}, 16'h0004);

    // load beats expiry at 00:01
    do_tick(); do_tick(); do_tick();
    chk("run_to_0001", {mt, mo, st, so}, 16'h0001);
    load = 1'b1; tick = 1'b1; load_mt = 4'd0; load_mo = 4'd0; load_st = 4'd0; load_so = 4'd1;
    step();
    load = 1'b0; tick = 1'b0;
    chk("load_beats_expiry", {13'd0, running, done, expired}, 16'd0);
    chk("load_beats_expiry_digits", {mt, mo, st, so}, 16'h0001);

    // reset beats tick at 00:01
    do_start();
    reset = 1'b1; tick = 1'b1;
    step();
    reset = 1'b0; tick = 1'b0;
    chk("reset_tick_digits", {mt, mo, st, so}, 16'h0000);
    chk("reset_tick_flags", {13'd0, running, done, expired}, 16'd0);
    do_start();
    chk("start_at_zero_idle", {13'd0, running, done, expired}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICK_EN_DEFAULT, default 1, meaning 1 = decrement only on tick pulses, 0 = decrement every clk cycle (simulation speed-up).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port tick  input  1  one-cycle 1 Hz enable pulse.
REQ-005 SHALL have port load  input  1  load preset digits, level sampled each cycle.
REQ-006 SHALL have port load_mt, load_mo, load_st, load_so  input  4 each  BCD preset: minute tens, minute ones, second tens, second ones.
REQ-007 SHALL have port start_resume  input  1  begin or resume counting.
REQ-008 SHALL have port stop  input  1  pause counting.
REQ-009 SHALL have port mt, mo, st, so  output  4 each  current BCD digits, registered.
REQ-010 SHALL have port running  output  1  high in RUN state.
REQ-011 SHALL have port done  output  1  one-cycle pulse on reaching 00:00.
REQ-012 SHALL have port expired  output  1  level, high in EXPIRED state.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, EXPIRED.
REQ-014 SHALL evaluate inputs in priority order reset > load > stop > start_resume > decrement.
REQ-015 SHALL, on load in any state, capture clamped presets next cycle and enter IDLE; running and expired deassert next cycle.
REQ-016 SHALL clamp presets: any digit >9 -> 9; load_st >5 -> 5.
REQ-017 SHALL, on stop in RUN, enter PAUSE with digits held; stop in IDLE/PAUSE/EXPIRED has no effect.
REQ-018 SHALL, on start_resume in IDLE or PAUSE with digits nonzero, enter RUN next cycle; with digits 00:00, stay in current state.
REQ-019 SHALL ignore start_resume in RUN and EXPIRED.
REQ-020 SHALL, in RUN, decrement once per enable (tick, or every cycle if TICK_EN_DEFAULT=0); the first decrement occurs on the first enable after entering RUN.
REQ-021 SHALL decrement with borrow chain: so 0->9 borrows st; st 0->5 borrows mo; mo 0->9 borrows mt; mt decrements.
REQ-022 SHALL never wrap below 00:00; a decrement from 00:01 yields 00:00.
REQ-023 SHALL, on the cycle digits become 00:00 in RUN, update state to EXPIRED and assert done for exactly that one cycle.
REQ-024 SHALL hold digits at 00:00 in EXPIRED until load or reset.
REQ-025 SHALL give stop priority over a coincident tick: no decrement that cycle.
REQ-026 SHALL give load priority over a coincident tick or expiry: done not asserted.
REQ-027 SHALL ignore tick outside RUN.
REQ-028 SHALL drive all outputs from registers; no combinational input-to-output paths.

Reset
REQ-029 SHALL, on reset high at posedge clk, set mt=mo=st=so=0, state IDLE, running=0, done=0, expired=0.
REQ-030 SHALL let reset override every other input, including mid-RUN and the expiry cycle.
REQ-031 SHALL resume normal operation on the first posedge after reset deasserts.

Verification
REQ-032 SHALL verify: load 01:00, start_resume, 1 tick -> 00:59, running=1.
REQ-033 SHALL verify: load 00:02, start_resume, 2 ticks -> 00:00, done high exactly 1 cycle, expired=1, running=0; further ticks leave 00:00.
REQ-034 SHALL verify: load 10:00, run 1 tick -> 09:59; load 00:10, 1 tick -> 00:09.
REQ-035 SHALL verify: load digits 0xF,0xA,0x7,0xC -> 99:59.
REQ-036 SHALL verify: in RUN at 00:05, stop and tick in the same cycle -> PAUSE at 00:05; start_resume then 1 tick -> 00:04.
REQ-037 SHALL verify: reset in the same cycle as tick at 00:01 -> 00:00, IDLE, done=0, expired=0; start_resume afterwards -> stays IDLE.
